grf_wport_arb: RTL
==================

// Module: grf_wport_arb
// PURPOSE
//   Shares the single GRF write port (Regw/rd/data/PC) between two writers:
//   A = main pipeline writeback (priority, no backpressure) and B = long-latency
//   unit (mult/div, valid/ready). B results wait in a 1-entry buffer; a wait
//   counter bounds B starvation by stalling the pipeline for one cycle.
//   Sits between the writeback stage and grf; exposes pending-write info to hazard logic.
// PARAMETERS
//   MAX_WAIT  4   cycles a full buffer may be blocked by A before stall_a forces a B grant (1..15)
// PORTS
//   clk         in   1   clock, all state updates on posedge
//   clr         in   1   synchronous active-high reset
//   a_we        in   1   writer A write enable
//   a_rd        in   5   writer A destination register
//   a_data      in   32  writer A write data
//   a_pc        in   32  writer A instruction PC (for write log)
//   b_valid     in   1   writer B result valid
//   b_rd        in   5   writer B destination register
//   b_data      in   32  writer B write data
//   b_pc        in   32  writer B instruction PC
//   b_ready     out  1   buffer can accept a B result this cycle
//   stall_a     out  1   pipeline must freeze and hold A inputs this cycle
//   Regw        out  1   to grf: write enable
//   rd          out  5   to grf: write address
//   data        out  32  to grf: write data
//   PC          out  32  to grf: PC of the write
//   pend_valid  out  1   B result buffered, not yet written
//   pend_rd     out  5   destination of buffered B result (0 when pend_valid=0)
// BEHAVIOUR
//   - Reset (clr=1 at posedge): buffer empty, wait count 0, state IDLE; Regw=0, rd=0,
//     data=0, PC=0, stall_a=0, pend_valid=0, pend_rd=0. b_ready=0 while clr high.
//   - b_ready = ~buf_full & ~clr (from registered state). B accepted on b_valid&b_ready at posedge.
//   - Grf outputs are registered: winner selected in cycle n drives Regw/rd/data/PC in
//     cycle n+1; grf commits at end of n+1. Regw=0 when no winner.
//   - A "uses port" when a_we=1 and a_rd!=0 and stall_a=0. A write to $0 yields Regw=0.
//   - B drain (buffer -> port) in cycle n when buf_full and A does not use port.
//     Buffered B with rd=0 is discarded on drain, Regw=0, buffer freed.
//   - Draining and accepting in the same cycle is not allowed (b_ready=0 while full).
//   - States: IDLE (buf empty) -> FULL on accept. FULL: drain -> IDLE, count=0;
//     blocked -> count+1; count==MAX_WAIT at posedge -> FORCE. FORCE: stall_a=1,
//     A ignored, buffer drains unconditionally -> IDLE, count=0. FORCE lasts exactly 1 cycle.
//   - stall_a is combinational from state only (=1 iff state FORCE).
//   - Same rd from A and pending B: no reordering; A writes first, B later overwrites.
//     Hazard unit uses pend_valid/pend_rd to prevent this; block does not check.
//   - clr mid-operation: buffered B result is dropped, any FORCE aborted.
// TESTING
//   1. A only: a_we=1,a_rd=5,a_data=0x1234,a_pc=0x3000 -> next cycle Regw=1,rd=5,data=0x1234,PC=0x3000.
//   2. A writes $0: a_we=1,a_rd=0 -> Regw=0 next cycle; B idle, b_ready stays 1.
//   3. B with A idle: b_valid=1,b_rd=8,b_data=0xAA accepted; next cycle drain -> following cycle Regw=1,rd=8,data=0xAA; pend_valid 1 for one cycle.
//   4. Starvation: B buffered rd=9, a_we=1 rd=3 every cycle -> blocked 4 cycles, then stall_a=1 for 1 cycle, rd=9 written, b_ready returns 1.
//   5. B rd=0 buffered -> discarded, Regw never 1 for it, b_ready back to 1 after 1 cycle.
//   6. clr asserted while state FORCE and buffer full -> next cycle stall_a=0, pend_valid=0, Regw=0, b_ready=1 after clr drops.

Source files
------------

// File: rtl/grf_wport_arb.sv
// grf_wport_arb: shares the single GRF write port between the pipeline
// writeback (writer A, priority, no backpressure) and a long-latency unit
// (writer B, valid/ready). B results wait in a one-entry buffer. A wait
// counter limits how long A may block a buffered B result. When the limit is
// reached, the pipeline is stalled for one cycle so that B can drain.
module grf_wport_arb #(
  parameter int unsigned MAX_WAIT = 4  // blocked cycles before a forced drain (1..15)
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        a_we,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic [31:0] a_pc,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  input  logic [31:0] b_pc,
  output logic        b_ready,
  output logic        stall_a,
  output logic        Regw,
  output logic [4:0]  rd,
  output logic [31:0] data,
  output logic [31:0] PC,
  output logic        pend_valid,
  output logic [4:0]  pend_rd
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // buffer empty
    ST_FULL  = 2'd1,  // buffer holds a B result, waiting for a free port slot
    ST_FORCE = 2'd2   // pipeline frozen, buffer drains unconditionally
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        regw_q, regw_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic [31:0] pc_q, pc_d;

  logic a_use;
  logic drain;
  logic b_accept;

  // A takes the port unless the write targets $0 or the pipeline is frozen.
  assign stall_a  = (state_q == ST_FORCE);
  assign a_use    = a_we && (a_rd != 5'd0) && !stall_a;
  assign drain    = ((state_q == ST_FULL) && !a_use) || (state_q == ST_FORCE);
  assign b_ready  = (state_q == ST_IDLE) && !clr;
  assign b_accept = b_valid && b_ready;

  assign pend_valid = (state_q != ST_IDLE);
  assign pend_rd    = pend_valid ? buf_rd_q : 5'd0;

  assign Regw = regw_q;
  assign rd   = rd_q;
  assign data = data_q;
  assign PC   = pc_q;

  // Select this cycle's port winner and compute the buffer and wait-counter next state.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    regw_d     = 1'b0;
    rd_d       = 5'd0;
    data_d     = 32'd0;
    pc_d       = 32'd0;

    if (a_use) begin
      regw_d = 1'b1;
      rd_d   = a_rd;
      data_d = a_data;
      pc_d   = a_pc;
    end else if (drain && (buf_rd_q != 5'd0)) begin
      // A buffered write to $0 is dropped silently on drain.
      regw_d = 1'b1;
      rd_d   = buf_rd_q;
      data_d = buf_data_q;
      pc_d   = buf_pc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (b_accept) begin
          state_d    = ST_FULL;
          cnt_d      = 4'd0;
          buf_rd_d   = b_rd;
          buf_data_d = b_data;
          buf_pc_d   = b_pc;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(MAX_WAIT)) state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Register state and the grf-facing outputs, with a synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      regw_q  <= 1'b0;
      rd_q    <= 5'd0;
      data_q  <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regw_q  <= regw_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  // Buffer payload is qualified by state, so it needs no reset.
  always_ff @(posedge clk) begin
    // NOTE: the payload registers are left unreset because pend_rd and the drain path only use them when the state is not IDLE.
    buf_rd_q   <= buf_rd_d;
    buf_data_q <= buf_data_d;
    buf_pc_q   <= buf_pc_d;
  end

endmodule
